etc_lane_arbiter: RTL and testbench

- Shares one speed-compute engine (ms-to-speed divider) among NUM_LANES toll lanes, each with its own sensor/E-pass front end.
- Lanes raise a level request once their sensor1->sensor2 interval is measured. The arbiter grants round-robin, starts the engine, waits for its result and returns speed plus done to the winning lane.
- Owns the per-lane barrier register: opens it on a valid E-pass, closes it on the lane's sensor3 clear pulse.

---
 rtl/etc_pkg.sv | 21 ++
 rtl/etc_rr_pick.sv | 29 ++
 rtl/etc_lane_arbiter.sv | 136 +++++++++++++
 tb/tb_etc_lane_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/etc_pkg.sv
// Shared encodings and default widths for the ETC lane arbiter and lane front ends.
package etc_pkg;

  localparam logic [1:0] EPASS_NONE  = 2'b00;
  localparam logic [1:0] EPASS_INV   = 2'b01;
  localparam logic [1:0] EPASS_VALID = 2'b10;
  localparam logic [1:0] EPASS_EXP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEF_NUM_LANES   = 4;
  localparam int DEF_WIDTH_MS    = 9;
  localparam int DEF_WIDTH_SPEED = 14;
  localparam int DEF_WIDTH_TIK   = 16;

endpackage

// File: rtl/etc_rr_pick.sv
// Rotate-priority encoder: first set req bit at or after ptr, wrapping around.
module etc_rr_pick #(
  parameter int NUM_LANES = 4,
  parameter int IW        = 2
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic                 found,
  output logic [IW-1:0]        idx
);

  int          j;
  logic [IW-1:0] jj;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    found = |req;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_LANES) j = j - NUM_LANES;
      jj = IW'(j);
      if (req[jj]) idx = jj;
    end
  end

endmodule

// File: rtl/etc_lane_arbiter.sv
// Round-robin arbiter sharing one speed engine among toll lanes; owns barriers.
// Optional over-speed flag enabled by defining ETC_SPEED_LIMIT_EN.
module etc_lane_arbiter
  import etc_pkg::*;
#(
  parameter int                     NUM_LANES   = DEF_NUM_LANES,
  parameter int                     WIDTH_MS    = DEF_WIDTH_MS,
  parameter int                     WIDTH_SPEED = DEF_WIDTH_SPEED,
  parameter int                     WIDTH_TIK   = DEF_WIDTH_TIK,
  parameter int                     TIMEOUT_CYC = 1000,
  parameter logic [WIDTH_SPEED-1:0] SPEED_LIMIT = 14'd80
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_LANES-1:0]          lane_req,
  input  logic [NUM_LANES*WIDTH_MS-1:0] lane_ms,
  input  logic [NUM_LANES*2-1:0]        lane_epass,
  input  logic [NUM_LANES-1:0]          lane_clear,
  output logic                          eng_start,
  output logic [WIDTH_MS-1:0]           eng_ms,
  input  logic                          eng_done,
  input  logic [WIDTH_SPEED-1:0]        eng_speed,
  output logic [NUM_LANES-1:0]          lane_grant,
  output logic [NUM_LANES-1:0]          lane_done,
  output logic                          lane_err,
  output logic [WIDTH_SPEED-1:0]        lane_speed,
  output logic                          lane_viol,
  output logic [NUM_LANES-1:0]          barrier
);

  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  state_t              state;
  logic [IW-1:0]       ptr_q, idx_q, pick_idx;
  logic                pick_found;
  logic [WIDTH_MS-1:0] ms_q;
  logic [1:0]          epass_q;
  logic [WIDTH_TIK-1:0] tik_q;
  logic                over_lim, bar_set;

  logic [WIDTH_MS-1:0] ms_arr [NUM_LANES];
  logic [1:0]          ep_arr [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_unpack
    assign ms_arr[g] = lane_ms[g*WIDTH_MS +: WIDTH_MS];
    assign ep_arr[g] = lane_epass[g*2 +: 2];
  end

  etc_rr_pick #(.NUM_LANES(NUM_LANES), .IW(IW)) u_pick (
    .req   (lane_req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ETC_SPEED_LIMIT_EN
  assign over_lim = (eng_speed > SPEED_LIMIT);
`else
  logic unused_lim;
  assign over_lim   = 1'b0;
  assign unused_lim = (eng_speed > SPEED_LIMIT);
`endif

  assign eng_ms = ms_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      ms_q       <= '0;
      epass_q    <= '0;
      tik_q      <= '0;
      eng_start  <= 1'b0;
      lane_grant <= '0;
      lane_done  <= '0;
      lane_err   <= 1'b0;
      lane_speed <= '0;
      lane_viol  <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      lane_done <= '0;
      case (state)
        ST_IDLE: if (pick_found) begin
          idx_q      <= pick_idx;
          ms_q       <= ms_arr[pick_idx];
          epass_q    <= ep_arr[pick_idx];
          lane_grant <= NUM_LANES'(1) << pick_idx;
          eng_start  <= 1'b1;
          state      <= ST_START;
        end
        ST_START: begin
          tik_q <= '0;
          state <= ST_WAIT;
        end
        // A result arriving on the timeout cycle still counts as success.
        ST_WAIT: if (eng_done) begin
          lane_speed <= eng_speed;
          lane_err   <= 1'b0;
          lane_viol  <= over_lim;
          lane_done  <= NUM_LANES'(1) << idx_q;
          state      <= ST_RESP;
        end else if (tik_q == WIDTH_TIK'(TIMEOUT_CYC - 1)) begin
          lane_speed <= '1;
          lane_err   <= 1'b1;
          lane_viol  <= 1'b0;
          lane_done  <= NUM_LANES'(1) << idx_q;
          state      <= ST_RESP;
        end else begin
          tik_q <= tik_q + 1'b1;
        end
        ST_RESP: begin
          ptr_q      <= (idx_q == IW'(NUM_LANES - 1)) ? '0 : idx_q + 1'b1;
          lane_grant <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bar_set = (state == ST_RESP) && (epass_q == EPASS_VALID) && !lane_err && !lane_viol;

  // Opening for a new car takes priority over a clear on the same lane.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      barrier <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bar_set && idx_q == IW'(i)) barrier[i] <= 1'b1;
        else if (lane_clear[i])         barrier[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_etc_lane_arbiter.sv
// Scoreboard bench for etc_lane_arbiter with a 3600/ms engine model.
module tb_etc_lane_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [N-1:0]  lane_req = '0;
  logic [N*9-1:0] lane_ms = '0;
  logic [N*2-1:0] lane_epass = '0;
  logic [N-1:0]  lane_clear = '0;
  logic          eng_start;
  logic [8:0]    eng_ms;
  logic          eng_done = 1'b0;
  logic [13:0]   eng_speed = '0;
  logic [N-1:0]  lane_grant, lane_done, barrier;
  logic          lane_err, lane_viol;
  logic [13:0]   lane_speed;

  always #5 clk = ~clk;

  etc_lane_arbiter #(
    .NUM_LANES(N), .WIDTH_MS(9), .WIDTH_SPEED(14), .WIDTH_TIK(16),
    .TIMEOUT_CYC(50), .SPEED_LIMIT(14'd80)
  ) dut (
    .clk(clk), .reset_n(reset_n), .lane_req(lane_req), .lane_ms(lane_ms),
    .lane_epass(lane_epass), .lane_clear(lane_clear), .eng_start(eng_start),
    .eng_ms(eng_ms), .eng_done(eng_done), .eng_speed(eng_speed),
    .lane_grant(lane_grant), .lane_done(lane_done), .lane_err(lane_err),
    .lane_speed(lane_speed), .lane_viol(lane_viol), .barrier(barrier)
  );

  typedef struct {
    int          lane;
    logic [13:0] spd;
    logic        err;
    logic        viol;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   eng_lat = 20;
  bit   eng_mute = 1'b0;
  int   start_cyc = -1;
  logic [8:0]   ms_seen = '0;
  logic [N-1:0] grant_seen = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit exp_viol(input logic [13:0] spd, input bit err);
`ifdef ETC_SPEED_LIMIT_EN
    return !err && (spd > 14'd80);
`else
    return 1'b0;
`endif
  endfunction

  // Engine model: speed = 3600 / ms, answered eng_lat cycles after eng_start.
  initial begin
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        start_cyc  = cyc;
        ms_seen    = eng_ms;
        grant_seen = lane_grant;
        if (!eng_mute) begin
          repeat (eng_lat) @(negedge clk);
          eng_done  = 1'b1;
          eng_speed = 14'(3600 / int'(ms_seen));
          @(negedge clk);
          eng_done  = 1'b0;
        end
      end
    end
  end

  // Monitor: every lane_done must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && lane_done != '0) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=%b expected=none", lane_done);
      end else begin
        e = sb.pop_front();
        chk("done_lane", lane_done, 64'(1) << e.lane);
        chk("speed", lane_speed, e.spd);
        chk("err", lane_err, e.err);
        chk("viol", lane_viol, e.viol);
      end
    end
  end

  task automatic set_lane(input int l, input logic [8:0] ms, input logic [1:0] ep);
    lane_ms[l*9 +: 9]    = ms;
    lane_epass[l*2 +: 2] = ep;
  endtask

  task automatic wait_done(input int l, input bit clr, output int dcyc);
    int n = 0;
    dcyc = -1;
    while (n < 200 && dcyc < 0) begin
      @(negedge clk);
      if (lane_done[l]) begin
        dcyc = cyc;
        lane_req[l] = 1'b0;
        if (clr) lane_clear[l] = 1'b1;
      end
      n++;
    end
    if (dcyc < 0) begin
      checks++; errors++;
      $display("FAIL wait_done lane=%0d actual=none expected=done", l);
      lane_req[l] = 1'b0;
    end
    if (clr) begin
      @(posedge clk); #1;
      lane_clear[l] = 1'b0;
    end
  endtask

  task automatic serve(input int l, input logic [8:0] ms, input logic [1:0] ep, input int lat,
                       input bit mute, input logic [13:0] spd, input bit clr);
    int rcyc, dcyc;
    bit err, viol;
    err  = mute;
    viol = exp_viol(spd, err);
    set_lane(l, ms, ep);
    eng_lat  = lat;
    eng_mute = mute;
    sb.push_back('{l, mute ? 14'h3FFF : spd, err, viol});
    @(posedge clk); #1;
    lane_req[l] = 1'b1;
    rcyc = cyc;
    wait_done(l, clr, dcyc);
    eng_mute = 1'b0;
    // eng_start lands in the cycle after the request is sampled in IDLE.
    chk("start_lat", 64'(start_cyc - rcyc), 64'(1));
    chk("eng_ms", ms_seen, ms);
    chk("grant", grant_seen, 64'(1) << l);
    chk("done_lat", 64'(dcyc - start_cyc), 64'(mute ? 51 : lat + 1));
    @(negedge clk);
    chk("barrier", barrier[l], (ep == 2'b10) && !err && !viol);
  endtask

  initial begin
    int d, n;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {eng_start, eng_ms, lane_grant, lane_done, lane_err, lane_speed, lane_viol, barrier}, 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Single lane, valid pass, then sensor3 clear.
    serve(0, 9'd100, 2'b10, 20, 1'b0, 14'd36, 1'b0);
    @(posedge clk); #1 lane_clear[0] = 1'b1;
    @(posedge clk); #1 lane_clear[0] = 1'b0;
    @(negedge clk);
    chk("barrier_clear", barrier[0], 1'b0);

    // Invalid and expired passes keep the barrier closed.
    serve(2, 9'd75, 2'b01, 4, 1'b0, 14'd48, 1'b0);
    serve(3, 9'd40, 2'b11, 4, 1'b0, 14'd90, 1'b0);

    // Round robin from pointer 0: 0,1,3 then lane 0 again after a wrap.
    eng_lat = 3;
    set_lane(0, 9'd90, 2'b00); set_lane(1, 9'd60, 2'b00); set_lane(3, 9'd72, 2'b00);
    sb.push_back('{0, 14'd40, 1'b0, 1'b0});
    sb.push_back('{1, 14'd60, 1'b0, 1'b0});
    sb.push_back('{3, 14'd50, 1'b0, 1'b0});
    sb.push_back('{0, 14'd36, 1'b0, 1'b0});
    @(posedge clk); #1 lane_req = 4'b1011;
    wait_done(0, 1'b0, d);
    wait_done(1, 1'b0, d);
    n = 0;
    while (n < 50 && !lane_grant[3]) begin @(negedge clk); n++; end
    chk("grant3_seen", lane_grant[3], 1'b1);
    set_lane(0, 9'd100, 2'b00);
    lane_req[0] = 1'b1;
    wait_done(3, 1'b0, d);
    wait_done(0, 1'b0, d);

    // Timeout, then eng_done exactly on the timeout cycle.
    serve(1, 9'd50, 2'b10, 0, 1'b1, 14'd0, 1'b0);
    serve(2, 9'd120, 2'b00, 50, 1'b0, 14'd30, 1'b0);

    // Set and clear on the same lane in the same cycle.
    serve(3, 9'd36, 2'b10, 5, 1'b0, 14'd100, 1'b1);

    // Speed threshold: 120 above, 80 exactly at the limit.
    serve(0, 9'd30, 2'b10, 6, 1'b0, 14'd120, 1'b0);
    serve(1, 9'd45, 2'b10, 6, 1'b0, 14'd80, 1'b0);

    // Reset during WAIT: everything drops at once, no lane_done, pointer back to 0.
    set_lane(2, 9'd60, 2'b10);
    eng_mute = 1'b1;
    d = start_cyc;
    @(posedge clk); #1 lane_req[2] = 1'b1;
    n = 0;
    while (n < 20 && start_cyc == d) begin @(negedge clk); n++; end
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk("reset_mid", {eng_start, eng_ms, lane_grant, lane_done, lane_err, lane_speed, lane_viol, barrier}, 64'd0);
    lane_req[2] = 1'b0;
    eng_mute = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    eng_lat = 4;
    set_lane(0, 9'd100, 2'b00); set_lane(2, 9'd60, 2'b00);
    sb.push_back('{0, 14'd36, 1'b0, 1'b0});
    sb.push_back('{2, 14'd60, 1'b0, 1'b0});
    @(posedge clk); #1 lane_req = 4'b0101;
    wait_done(0, 1'b0, d);
    wait_done(2, 1'b0, d);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
